hermes_rx_framer: RTL and testbench

- Input stage between the Hermes router local output port and the DMNI Hermes input (noc_rx_i / noc_credit_o / noc_data_i).
- Buffers incoming flits in a 2-entry skid buffer and forwards them unchanged.
- Tracks packet framing (header flit, size flit, then size payload flits) and tags sop/eop on the forwarded flit.
- Provides packet statistics and in-packet status to software/debug.

---
 rtl/hermes_rx_framer_pkg.sv | 13 +
 rtl/hermes_rx_skid.sv | 62 ++++++
 rtl/hermes_rx_framer.sv | 116 +++++++++++
 tb/tb_hermes_rx_framer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hermes_rx_framer_pkg.sv
// Shared types and constants for the Hermes receive framer.
// The watchdog is built only when HERMES_RX_WATCHDOG_EN is defined.
package hermes_rx_framer_pkg;

    localparam int HERMES_RX_SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        HERMES_RX_HEADER  = 2'd0,
        HERMES_RX_SIZE    = 2'd1,
        HERMES_RX_PAYLOAD = 2'd2
    } hermes_rx_state_t;

endpackage

// File: rtl/hermes_rx_skid.sv
// Two-entry FIFO skid buffer between the router port and the DMNI.
// credit_o comes from registered occupancy only, so it never depends on credit_i.
module hermes_rx_skid
    import hermes_rx_framer_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         rx_i,
    output logic         credit_o,
    input  logic [W-1:0] data_i,
    output logic         tx_o,
    input  logic         credit_i,
    output logic [W-1:0] data_o
);

    localparam logic [1:0] DEPTH = 2'(HERMES_RX_SKID_DEPTH);

    logic [1:0]   count_q;
    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic         push;
    logic         pop;

    assign credit_o = (count_q != DEPTH);
    assign tx_o     = (count_q != 2'd0);
    assign data_o   = head_q;
    assign push     = rx_i && credit_o;
    assign pop      = tx_o && credit_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_q <= data_i;
                    else                 tail_q <= data_i;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new flit lands behind whatever remains.
                    if (count_q == 2'd1) begin
                        head_q <= data_i;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= data_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/hermes_rx_framer.sv
// Hermes receive framer: skid buffer plus header/size/payload tracking and packet stats.
// Optional stall watchdog enabled by defining HERMES_RX_WATCHDOG_EN.
module hermes_rx_framer
    import hermes_rx_framer_pkg::*;
#(
    parameter int HERMES_FLIT_SIZE = 32,
    parameter int CNT_WIDTH        = 16,
    parameter int WDT_CYCLES       = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        rx_i,
    output logic                        credit_o,
    input  logic [HERMES_FLIT_SIZE-1:0] data_i,
    output logic                        tx_o,
    input  logic                        credit_i,
    output logic [HERMES_FLIT_SIZE-1:0] data_o,
    output logic                        sop_o,
    output logic                        eop_o,
    output logic                        in_packet_o,
    output logic [CNT_WIDTH-1:0]        pkt_count_o,
    input  logic                        cnt_clr_i,
    output logic                        err_timeout_o
);

    hermes_rx_state_t            state_q;
    logic [HERMES_FLIT_SIZE-1:0] remaining_q;
    logic [CNT_WIDTH-1:0]        pkt_count_q;
    logic                        xfer;
    logic                        pkt_last;
    logic                        pkt_done;

    hermes_rx_skid #(.W(HERMES_FLIT_SIZE)) u_skid (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .rx_i     (rx_i),
        .credit_o (credit_o),
        .data_i   (data_i),
        .tx_o     (tx_o),
        .credit_i (credit_i),
        .data_o   (data_o)
    );

    assign xfer = tx_o && credit_i;

    always_comb begin
        pkt_last = 1'b0;
        case (state_q)
            HERMES_RX_SIZE:    pkt_last = (data_o == '0);
            HERMES_RX_PAYLOAD: pkt_last = (remaining_q == HERMES_FLIT_SIZE'(1));
            default:           pkt_last = 1'b0;
        endcase
    end

    assign sop_o       = tx_o && (state_q == HERMES_RX_HEADER);
    assign eop_o       = tx_o && pkt_last;
    assign pkt_done    = xfer && pkt_last;
    assign in_packet_o = (state_q != HERMES_RX_HEADER);
    assign pkt_count_o = pkt_count_q;

    // Framing advances only on flits actually handed to the DMNI.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= HERMES_RX_HEADER;
            remaining_q <= '0;
        end else if (xfer) begin
            case (state_q)
                HERMES_RX_HEADER: state_q <= HERMES_RX_SIZE;
                HERMES_RX_SIZE: begin
                    remaining_q <= data_o;
                    state_q     <= (data_o == '0) ? HERMES_RX_HEADER : HERMES_RX_PAYLOAD;
                end
                HERMES_RX_PAYLOAD: begin
                    remaining_q <= remaining_q - HERMES_FLIT_SIZE'(1);
                    if (remaining_q == HERMES_FLIT_SIZE'(1)) state_q <= HERMES_RX_HEADER;
                end
                default: state_q <= HERMES_RX_HEADER;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       pkt_count_q <= '0;
        else if (cnt_clr_i) pkt_count_q <= '0;
        else if (pkt_done)  pkt_count_q <= pkt_count_q + CNT_WIDTH'(1);
    end

`ifdef HERMES_RX_WATCHDOG_EN
    localparam int                WDT_W    = $clog2(WDT_CYCLES + 1);
    localparam logic [WDT_W-1:0]  WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] stall_q;
    logic             err_q;
    logic             stalling;

    // Returning to HEADER drops in_packet_o, which also clears the counter.
    assign stalling      = in_packet_o && !xfer;
    assign err_timeout_o = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (!stalling)             stall_q <= '0;
            else if (stall_q != WDT_LAST) stall_q <= stall_q + WDT_W'(1);

            if (cnt_clr_i)                           err_q <= 1'b0;
            else if (stalling && stall_q == WDT_LAST) err_q <= 1'b1;
        end
    end
`else
    assign err_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_hermes_rx_framer.sv
// Directed bench for hermes_rx_framer; a narrow packet counter makes the wrap reachable.
// Watchdog expectations follow HERMES_RX_WATCHDOG_EN.
module tb_hermes_rx_framer;

    localparam int W  = 32;
    localparam int CW = 8;

`ifdef HERMES_RX_WATCHDOG_EN
    localparam logic WDT_ON = 1'b1;
`else
    localparam logic WDT_ON = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          rx_i = 1'b0;
    logic          credit_o;
    logic [W-1:0]  data_i = '0;
    logic          tx_o;
    logic          credit_i = 1'b0;
    logic [W-1:0]  data_o;
    logic          sop_o;
    logic          eop_o;
    logic          in_packet_o;
    logic [CW-1:0] pkt_count_o;
    logic          cnt_clr_i = 1'b0;
    logic          err_timeout_o;

    int vectors = 0;
    int miscompares = 0;
    int credit_low = 0;
    int steps_taken = 0;

    logic [W-1:0]  src_q[$];
    logic [W+1:0]  exp_q[$];   // {sop, eop, data}

    hermes_rx_framer #(
        .HERMES_FLIT_SIZE (W),
        .CNT_WIDTH        (CW),
        .WDT_CYCLES       (16)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .rx_i          (rx_i),
        .credit_o      (credit_o),
        .data_i        (data_i),
        .tx_o          (tx_o),
        .credit_i      (credit_i),
        .data_o        (data_o),
        .sop_o         (sop_o),
        .eop_o         (eop_o),
        .in_packet_o   (in_packet_o),
        .pkt_count_o   (pkt_count_o),
        .cnt_clr_i     (cnt_clr_i),
        .err_timeout_o (err_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500us;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_flit(input logic [W-1:0] d, input logic s, input logic e);
        src_q.push_back(d);
        exp_q.push_back({s, e, d});
    endtask

    // One clock: drive source, score any flit leaving this edge, end on the negedge.
    task automatic step();
        logic         acc;
        logic [W-1:0] d;
        logic [W+1:0] e;
        rx_i   = (src_q.size() != 0);
        data_i = rx_i ? src_q[0] : '0;
        acc    = rx_i && credit_o;
        if (!credit_o) credit_low++;
        if (tx_o && credit_i) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL extra_flit observed=0x%0h expected=none", data_o);
            end else begin
                e = exp_q.pop_front();
                chk("flit", {sop_o, eop_o, data_o}, e);
            end
        end
        @(posedge clk_i);
        if (acc) d = src_q.pop_front();
        @(negedge clk_i);
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        rx_i = 1'b0;
        steps_taken = n;
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        // Reset state
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_tx", tx_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_sop_eop", {sop_o, eop_o}, 0);
        chk("rst_in_packet", in_packet_o, 0);
        chk("rst_pkt_count", pkt_count_o, 0);
        chk("rst_err", err_timeout_o, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_credit", credit_o, 1);

        // Basic packet, size 3, with one-cycle latency
        credit_i = 1'b1;
        push_flit(32'h0000_0102, 1, 0);
        push_flit(32'h0000_0003, 0, 0);
        push_flit(32'h0000_000A, 0, 0);
        push_flit(32'h0000_000B, 0, 0);
        push_flit(32'h0000_000C, 0, 1);
        step();
        chk("lat_tx", tx_o, 1);
        chk("lat_data", data_o, 32'h0000_0102);
        chk("lat_sop", sop_o, 1);
        step();
        chk("p1_in_packet", in_packet_o, 1);
        drain("p1_drain", 50);
        chk("p1_count", pkt_count_o, 1);
        chk("p1_in_packet_end", in_packet_o, 0);

        // Size-0 packets: eop on the size flit, next header gets sop
        push_flit(32'h0000_0200, 1, 0);
        push_flit(32'h0000_0000, 0, 1);
        push_flit(32'h0000_0300, 1, 0);
        push_flit(32'h0000_0000, 0, 1);
        drain("z_drain", 50);
        chk("z_count", pkt_count_o, 3);
        chk("z_in_packet", in_packet_o, 0);

        // Sink stall: credit drops after two accepted flits, head held
        credit_i = 1'b0;
        push_flit(32'h0000_0400, 1, 0);
        push_flit(32'h0000_0002, 0, 0);
        push_flit(32'h0000_000D, 0, 0);
        push_flit(32'h0000_000E, 0, 1);
        step();
        chk("stall_credit_1", credit_o, 1);
        step();
        chk("stall_credit_0", credit_o, 0);
        chk("stall_tx", tx_o, 1);
        chk("stall_sop", sop_o, 1);
        repeat (8) step();
        chk("stall_data_held", data_o, 32'h0000_0400);
        chk("stall_credit_held", credit_o, 0);
        chk("stall_src_left", src_q.size(), 2);
        credit_i = 1'b1;
        drain("stall_drain", 50);
        chk("stall_count", pkt_count_o, 4);

        // Back-to-back packets at full rate
        credit_low = 0;
        push_flit(32'h0000_0500, 1, 0);
        push_flit(32'h0000_0001, 0, 0);
        push_flit(32'h0000_0011, 0, 1);
        push_flit(32'h0000_0600, 1, 0);
        push_flit(32'h0000_0000, 0, 1);
        push_flit(32'h0000_0700, 1, 0);
        push_flit(32'h0000_0002, 0, 0);
        push_flit(32'h0000_0022, 0, 0);
        push_flit(32'h0000_0033, 0, 1);
        drain("b2b_drain", 50);
        chk("b2b_cycles", steps_taken, 10);
        chk("b2b_credit_low", credit_low, 0);
        chk("b2b_count", pkt_count_o, 7);

        // Counter wrap
        cnt_clr_i = 1'b1;
        step();
        cnt_clr_i = 1'b0;
        chk("clr_count", pkt_count_o, 0);
        for (int i = 0; i < 255; i++) begin
            push_flit(32'h0001_0000 + i, 1, 0);
            push_flit(32'h0000_0000, 0, 1);
        end
        drain("wrap_fill_drain", 2000);
        chk("wrap_full", pkt_count_o, 8'hFF);
        push_flit(32'h0000_0800, 1, 0);
        push_flit(32'h0000_0000, 0, 1);
        drain("wrap_drain", 50);
        chk("wrap_zero", pkt_count_o, 0);

        // Clear coinciding with packet end
        push_flit(32'h0000_0810, 1, 0);
        push_flit(32'h0000_0000, 0, 1);
        drain("pre_clr_drain", 50);
        chk("pre_clr_count", pkt_count_o, 1);
        push_flit(32'h0000_0900, 1, 0);
        push_flit(32'h0000_0000, 0, 1);
        step();
        step();
        chk("clr_eop_head", eop_o, 1);
        cnt_clr_i = 1'b1;
        step();
        cnt_clr_i = 1'b0;
        chk("clr_vs_inc", pkt_count_o, 0);
        chk("clr_exp_empty", exp_q.size(), 0);

        // Watchdog: 15-cycle stall stays quiet, 16-cycle stall trips and sticks
        push_flit(32'h0000_0A00, 1, 0);
        push_flit(32'h0000_0002, 0, 0);
        push_flit(32'h0000_0055, 0, 0);
        push_flit(32'h0000_0066, 0, 1);
        step();
        step();
        credit_i = 1'b0;
        chk("wdt_in_packet", in_packet_o, 1);
        repeat (15) step();
        chk("wdt_15", err_timeout_o, 0);
        credit_i = 1'b1;
        step();
        credit_i = 1'b0;
        repeat (16) step();
        chk("wdt_16", err_timeout_o, WDT_ON);
        credit_i = 1'b1;
        drain("wdt_drain", 50);
        chk("wdt_sticky", err_timeout_o, WDT_ON);
        chk("wdt_count", pkt_count_o, 1);
        cnt_clr_i = 1'b1;
        step();
        cnt_clr_i = 1'b0;
        chk("wdt_cleared", err_timeout_o, 0);

        // Reset mid-packet drops the partial packet
        push_flit(32'h0000_0B00, 1, 0);
        push_flit(32'h0000_0005, 0, 0);
        step();
        step();
        chk("mid_in_packet", in_packet_o, 1);
        rst_ni = 1'b0;
        rx_i   = 1'b0;
        src_q.delete();
        exp_q.delete();
        #1;
        chk("mid_rst_tx", tx_o, 0);
        chk("mid_rst_in_packet", in_packet_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("mid_rst_credit", credit_o, 1);
        push_flit(32'h0000_0C00, 1, 0);
        push_flit(32'h0000_0000, 0, 1);
        drain("mid_drain", 50);
        chk("mid_count", pkt_count_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
